// File: rtl/cpu_controller.sv
// cpu_controller: 8-phase instruction sequencer for the 8-bit RISC CPU.
// A phase counter plus a halted flag are the only state. The strobes are decoded
// combinationally from phase, halted, opcode and zero.
module cpu_controller #(
   parameter int unsigned OPC_W   = 3,
   parameter int unsigned PHASE_W = 3
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               enable,
   input  logic [OPC_W-1:0]   opcode,
   input  logic               zero,
   output logic               sel,
   output logic               rd,
   output logic               ld_ir,
   output logic               inc_pc,
   output logic               ld_pc,
   output logic               ld_ac,
   output logic               wr,
   output logic               data_e,
   output logic               halt,
   output logic               instr_done,
   output logic [PHASE_W-1:0] phase
);

   localparam logic [OPC_W-1:0] OP_HLT = OPC_W'(0);
   localparam logic [OPC_W-1:0] OP_SKZ = OPC_W'(1);
   localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(2);
   localparam logic [OPC_W-1:0] OP_AND = OPC_W'(3);
   localparam logic [OPC_W-1:0] OP_XOR = OPC_W'(4);
   localparam logic [OPC_W-1:0] OP_LDA = OPC_W'(5);
   localparam logic [OPC_W-1:0] OP_STO = OPC_W'(6);
   localparam logic [OPC_W-1:0] OP_JMP = OPC_W'(7);

   typedef enum logic [PHASE_W-1:0] {
      INST_ADDR  = PHASE_W'(0),
      INST_FETCH = PHASE_W'(1),
      INST_LOAD  = PHASE_W'(2),
      IDLE       = PHASE_W'(3),
      OP_ADDR    = PHASE_W'(4),
      OP_FETCH   = PHASE_W'(5),
      ALU_OP     = PHASE_W'(6),
      STORE      = PHASE_W'(7)
   } phase_t;

   phase_t phase_q;
   logic   halted_q;
   logic   is_alu;
   logic   is_skz;
   logic   is_sto;
   logic   is_jmp;
   logic   is_hlt;

   assign is_alu = (opcode == OP_ADD) || (opcode == OP_AND) ||
                   (opcode == OP_XOR) || (opcode == OP_LDA);
   assign is_skz = (opcode == OP_SKZ);
   assign is_sto = (opcode == OP_STO);
   assign is_jmp = (opcode == OP_JMP);
   assign is_hlt = (opcode == OP_HLT);

   assign phase  = phase_q;

   // Phase sequencer: advance on enable, freeze in OP_ADDR once HLT is seen.
   always_ff @(posedge clock) begin
      if (reset) begin
         phase_q  <= INST_ADDR;
         halted_q <= 1'b0;
      end else if (enable && !halted_q) begin
         if (phase_q == OP_ADDR && is_hlt) begin
            halted_q <= 1'b1;
         end else if (phase_q == STORE) begin
            phase_q <= INST_ADDR;
         end else begin
            phase_q <= phase_t'(phase_q + PHASE_W'(1));
         end
      end
   end

   // Strobe decode from phase and opcode, then halt and stall gating.
   always_comb begin
      sel        = 1'b0;
      rd         = 1'b0;
      ld_ir      = 1'b0;
      inc_pc     = 1'b0;
      ld_pc      = 1'b0;
      ld_ac      = 1'b0;
      wr         = 1'b0;
      data_e     = 1'b0;
      halt       = 1'b0;
      instr_done = 1'b0;

      case (phase_q)
         INST_ADDR: begin
            sel = 1'b1;
         end
         INST_FETCH: begin
            sel = 1'b1;
            rd  = 1'b1;
         end
         INST_LOAD, IDLE: begin
            sel   = 1'b1;
            rd    = 1'b1;
            ld_ir = 1'b1;
         end
         OP_ADDR: begin
            inc_pc = 1'b1;
            halt   = is_hlt;
         end
         OP_FETCH: begin
            rd = is_alu;
         end
         ALU_OP: begin
            rd     = is_alu;
            inc_pc = is_skz && zero;
            ld_pc  = is_jmp;
            data_e = is_sto;
         end
         STORE: begin
            rd     = is_alu;
            ld_ac  = is_alu;
            ld_pc  = is_jmp;
            inc_pc = is_jmp;
            wr     = is_sto;
            data_e = is_sto;
         end
         default: begin
            sel = 1'b0;
         end
      endcase

      if (halted_q) begin
         // Halted: nothing but the halt indication, address mux parked on IR.
         sel    = 1'b0;
         rd     = 1'b0;
         ld_ir  = 1'b0;
         inc_pc = 1'b0;
         ld_pc  = 1'b0;
         ld_ac  = 1'b0;
         wr     = 1'b0;
         data_e = 1'b0;
         halt   = 1'b1;
      end else if (!enable) begin
         // Stalled: suppress every side effect but keep sel and halt visible.
         rd     = 1'b0;
         ld_ir  = 1'b0;
         inc_pc = 1'b0;
         ld_pc  = 1'b0;
         ld_ac  = 1'b0;
         wr     = 1'b0;
         data_e = 1'b0;
      end

      instr_done = (phase_q == STORE) && enable && !halted_q;
   end

endmodule

// File: tb/tb_cpu_controller.sv
// tb_cpu_controller: directed scenarios plus randomized stimulus, checked against
// a behavioural model of the sequencer (phase number, halted flag, rule-based strobes).
module tb_cpu_controller;

   logic       clock = 1'b0;
   logic       reset;
   logic       enable;
   logic [2:0] opcode;
   logic       zero;
   logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt, instr_done;
   logic [2:0] phase;

   int checks = 0;
   int errors = 0;

   // Reference model state
   int m_ph;
   bit m_hl;

   cpu_controller #(.OPC_W(3), .PHASE_W(3)) dut (
      .clock      (clock),
      .reset      (reset),
      .enable     (enable),
      .opcode     (opcode),
      .zero       (zero),
      .sel        (sel),
      .rd         (rd),
      .ld_ir      (ld_ir),
      .inc_pc     (inc_pc),
      .ld_pc      (ld_pc),
      .ld_ac      (ld_ac),
      .wr         (wr),
      .data_e     (data_e),
      .halt       (halt),
      .instr_done (instr_done),
      .phase      (phase)
   );

   always #5 clock = ~clock;

   // Observed outputs as {sel,rd,ld_ir,inc_pc,ld_pc,ld_ac,wr,data_e,halt,instr_done}
   function automatic logic [9:0] dut_out();
      return {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt, instr_done};
   endfunction

   // Expected outputs from the instruction rules for the model's current phase
   function automatic logic [9:0] model_out();
      bit alu, s, r, ir, inc, lpc, lac, w, de, h, d;
      int p;
      p   = m_ph;
      alu = (opcode == 3'd2) || (opcode == 3'd3) || (opcode == 3'd4) || (opcode == 3'd5);
      s   = (p <= 3);
      r   = (p >= 1 && p <= 3) || (alu && p >= 5);
      ir  = (p == 2) || (p == 3);
      inc = (p == 4) || (opcode == 3'd1 && zero && p == 6) || (opcode == 3'd7 && p == 7);
      lpc = (opcode == 3'd7) && (p >= 6);
      lac = alu && (p == 7);
      w   = (opcode == 3'd6) && (p == 7);
      de  = (opcode == 3'd6) && (p >= 6);
      h   = m_hl || (p == 4 && opcode == 3'd0);
      if (m_hl) begin
         s = 0; r = 0; ir = 0; inc = 0; lpc = 0; lac = 0; w = 0; de = 0;
      end else if (!enable) begin
         r = 0; ir = 0; inc = 0; lpc = 0; lac = 0; w = 0; de = 0;
      end
      d = (p == 7) && enable && !m_hl;
      return {s, r, ir, inc, lpc, lac, w, de, h, d};
   endfunction

   // One clock: model follows the same inputs at the edge; returns at the falling edge
   task automatic tick();
      @(posedge clock);
      if (reset) begin
         m_ph = 0;
         m_hl = 0;
      end else if (enable && !m_hl) begin
         if (m_ph == 4 && opcode == 3'd0) m_hl = 1;
         else m_ph = (m_ph + 1) % 8;
      end
      @(negedge clock);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset  = 1'b1;
      enable = 1'($urandom_range(0, 1));
      opcode = 3'($urandom_range(0, 7));
      zero   = 1'b0;
      tick();
      reset  = 1'b0;
      enable = 1'b1;
      #1;
      checks++;
      if (phase !== 3'd0) begin
         errors++;
         $display("FAIL reset_phase got=%0d exp=0", phase);
      end
      checks++;
      if (dut_out() !== 10'b1000000000) begin
         errors++;
         $display("FAIL reset_outputs got=%b exp=%b", dut_out(), 10'b1000000000);
      end
   endtask

   task automatic test_lda();
      int done_cnt;
      done_cnt = 0;
      do_reset();
      opcode = 3'd5; enable = 1'b1; zero = 1'($urandom_range(0, 1));
      for (int i = 0; i < 16; i++) begin
         #1;
         checks++;
         if (phase !== 3'(i % 8)) begin
            errors++;
            $display("FAIL lda_phase cyc%0d got=%0d exp=%0d", i, phase, i % 8);
         end
         checks++;
         if (dut_out() !== model_out()) begin
            errors++;
            $display("FAIL lda_outputs ph%0d got=%b exp=%b", m_ph, dut_out(), model_out());
         end
         if (instr_done) done_cnt++;
         tick();
      end
      checks++;
      if (done_cnt !== 2) begin
         errors++;
         $display("FAIL lda_done_count got=%0d exp=2", done_cnt);
      end
   endtask

   // Runs one full instruction of the given opcode from phase 0 against the model
   task automatic test_instr(input logic [2:0] op, input logic z, input string name);
      int wr_cnt, inc_cnt;
      wr_cnt = 0; inc_cnt = 0;
      do_reset();
      opcode = op; zero = z; enable = 1'b1;
      for (int i = 0; i < 8; i++) begin
         #1;
         checks++;
         if (phase !== 3'(m_ph) || dut_out() !== model_out()) begin
            errors++;
            $display("FAIL %s ph%0d got=%0d/%b exp=%0d/%b", name, m_ph, phase, dut_out(),
                     m_ph, model_out());
         end
         if (wr) wr_cnt++;
         if (inc_pc) inc_cnt++;
         tick();
      end
      checks++;
      if (wr_cnt !== ((op == 3'd6) ? 1 : 0)) begin
         errors++;
         $display("FAIL %s_wr_count got=%0d", name, wr_cnt);
      end
      checks++;
      if (inc_cnt !== ((op == 3'd1 && z) || op == 3'd7 ? 2 : 1)) begin
         errors++;
         $display("FAIL %s_inc_count got=%0d", name, inc_cnt);
      end
   endtask

   task automatic test_hlt();
      do_reset();
      opcode = 3'd0; enable = 1'b1; zero = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      #1;
      checks++;
      if (phase !== 3'd4 || halt !== 1'b1 || inc_pc !== 1'b1) begin
         errors++;
         $display("FAIL hlt_entry got ph=%0d halt=%b inc=%b exp ph=4 halt=1 inc=1",
                  phase, halt, inc_pc);
      end
      tick();
      for (int i = 0; i < 20; i++) begin
         opcode = 3'($urandom_range(0, 7));
         zero   = 1'($urandom_range(0, 1));
         enable = 1'($urandom_range(0, 3) != 0);
         #1;
         checks++;
         if (phase !== 3'd4 || dut_out() !== 10'b0000000010) begin
            errors++;
            $display("FAIL hlt_hold cyc%0d got=%0d/%b exp=4/%b", i, phase, dut_out(),
                     10'b0000000010);
         end
         tick();
      end
      do_reset();
      enable = 1'b1;
      #1;
      checks++;
      if (phase !== 3'd0 || halt !== 1'b0 || sel !== 1'b1) begin
         errors++;
         $display("FAIL hlt_reset got ph=%0d halt=%b sel=%b exp ph=0 halt=0 sel=1",
                  phase, halt, sel);
      end
   endtask

   task automatic test_stall();
      do_reset();
      opcode = 3'd2; enable = 1'b1; zero = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      enable = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (phase !== 3'd6 || rd !== 1'b0 || dut_out() !== model_out()) begin
            errors++;
            $display("FAIL stall_hold cyc%0d got=%0d/%b exp=6/%b", i, phase, dut_out(),
                     model_out());
         end
         tick();
      end
      enable = 1'b1;
      #1;
      checks++;
      if (phase !== 3'd6 || rd !== 1'b1) begin
         errors++;
         $display("FAIL stall_resume got ph=%0d rd=%b exp ph=6 rd=1", phase, rd);
      end
      tick();
      #1;
      checks++;
      if (phase !== 3'd7 || ld_ac !== 1'b1 || instr_done !== 1'b1) begin
         errors++;
         $display("FAIL stall_store got ph=%0d ld_ac=%b done=%b exp 7/1/1",
                  phase, ld_ac, instr_done);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      opcode = 3'd2; enable = 1'b1; zero = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 7; i++) begin
         #1;
         checks++;
         if (phase !== 3'(i) || ld_ac !== 1'b0 || dut_out() !== model_out()) begin
            errors++;
            $display("FAIL reset_mid cyc%0d got=%0d/%b exp=%0d/%b", i, phase, dut_out(),
                     i, model_out());
         end
         tick();
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 400; i++) begin
         reset  = 1'($urandom_range(0, 49) == 0);
         enable = 1'($urandom_range(0, 9) != 0);
         // Mostly non-HLT so the run keeps executing instructions
         opcode = ($urandom_range(0, 15) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
         zero   = 1'($urandom_range(0, 1));
         #1;
         checks++;
         if (phase !== 3'(m_ph) || dut_out() !== model_out()) begin
            errors++;
            $display("FAIL random cyc%0d op=%0d en=%b z=%b got=%0d/%b exp=%0d/%b", i,
                     opcode, enable, zero, phase, dut_out(), m_ph, model_out());
         end
         tick();
      end
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; enable = 1'b0; opcode = 3'd0; zero = 1'b0;
      m_ph = 0; m_hl = 0;
      test_reset();
      test_lda();
      test_instr(3'd6, 1'b0, "sto");
      test_instr(3'd1, 1'b1, "skz_z1");
      test_instr(3'd1, 1'b0, "skz_z0");
      test_instr(3'd7, 1'b1, "jmp");
      test_instr(3'd4, 1'b0, "xor");
      test_hlt();
      test_stall();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
